// File: rtl/mem_arbiter.sv
// Two-into-one round-robin arbiter: one registered transaction at a time from port A or B
// onto a single downstream memory port, with the completion routed back to the issuer.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmem_read_a,
  input  logic                    cmem_write_a,
  input  logic [ADDR_WIDTH-1:0]   cmem_address_a,
  input  logic [DATA_WIDTH-1:0]   cmem_wdata_a,
  input  logic [DATA_WIDTH/8-1:0] cmem_byte_enable_a,
  output logic                    cmem_resp_a,
  output logic [DATA_WIDTH-1:0]   cmem_rdata_a,
  input  logic                    cmem_read_b,
  input  logic                    cmem_write_b,
  input  logic [ADDR_WIDTH-1:0]   cmem_address_b,
  input  logic [DATA_WIDTH-1:0]   cmem_wdata_b,
  input  logic [DATA_WIDTH/8-1:0] cmem_byte_enable_b,
  output logic                    cmem_resp_b,
  output logic [DATA_WIDTH-1:0]   cmem_rdata_b,
  output logic                    pmem_read,
  output logic                    pmem_write,
  output logic [ADDR_WIDTH-1:0]   pmem_address,
  output logic [DATA_WIDTH-1:0]   pmem_wdata,
  output logic [DATA_WIDTH/8-1:0] pmem_byte_enable,
  input  logic                    pmem_resp,
  input  logic [DATA_WIDTH-1:0]   pmem_rdata
);

  typedef enum logic [1:0] {StIdle, StServeA, StServeB} state_e;

  state_e                  r_state, w_state_d;
  logic                    r_last_b, w_last_b_d;
  logic                    r_read, w_read_d;
  logic                    r_write, w_write_d;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_d;
  logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_d;
  logic [DATA_WIDTH/8-1:0] r_be, w_be_d;

  logic w_req_a, w_req_b, w_grant_a, w_grant_b;

  assign w_req_a   = cmem_read_a | cmem_write_a;
  assign w_req_b   = cmem_read_b | cmem_write_b;
  // On a conflict the port that did not win last time goes first.
  assign w_grant_a = w_req_a & (~w_req_b | r_last_b);
  assign w_grant_b = w_req_b & ~w_grant_a;

  always_comb begin
    w_state_d  = r_state;
    w_last_b_d = r_last_b;
    w_read_d   = r_read;
    w_write_d  = r_write;
    w_addr_d   = r_addr;
    w_wdata_d  = r_wdata;
    w_be_d     = r_be;
    case (r_state)
      StIdle: begin
        if (w_grant_a) begin
          w_state_d  = StServeA;
          w_last_b_d = 1'b0;
          w_write_d  = cmem_write_a;
          w_read_d   = cmem_read_a & ~cmem_write_a;
          w_addr_d   = cmem_address_a;
          w_wdata_d  = cmem_wdata_a;
          w_be_d     = cmem_byte_enable_a;
        end else if (w_grant_b) begin
          w_state_d  = StServeB;
          w_last_b_d = 1'b1;
          w_write_d  = cmem_write_b;
          w_read_d   = cmem_read_b & ~cmem_write_b;
          w_addr_d   = cmem_address_b;
          w_wdata_d  = cmem_wdata_b;
          w_be_d     = cmem_byte_enable_b;
        end
      end
      StServeA, StServeB: begin
        if (pmem_resp) begin
          w_state_d = StIdle;
          w_read_d  = 1'b0;
          w_write_d = 1'b0;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_read_d  = 1'b0;
        w_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_last_b <= 1'b1;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
    end else begin
      r_state  <= w_state_d;
      r_last_b <= w_last_b_d;
      r_read   <= w_read_d;
      r_write  <= w_write_d;
      r_addr   <= w_addr_d;
      r_wdata  <= w_wdata_d;
      r_be     <= w_be_d;
    end
  end

  assign pmem_read        = r_read;
  assign pmem_write       = r_write;
  assign pmem_address     = r_addr;
  assign pmem_wdata       = r_wdata;
  assign pmem_byte_enable = r_be;

  assign cmem_resp_a  = (r_state == StServeA) & pmem_resp;
  assign cmem_resp_b  = (r_state == StServeB) & pmem_resp;
  assign cmem_rdata_a = pmem_rdata;
  assign cmem_rdata_b = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle, directed scenarios with
// literal expectations, and a downstream responder with programmable latency.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmem_read_a, cmem_write_a, cmem_read_b, cmem_write_b;
  logic [31:0] cmem_address_a, cmem_wdata_a, cmem_address_b, cmem_wdata_b;
  logic [3:0]  cmem_byte_enable_a, cmem_byte_enable_b;
  logic        cmem_resp_a, cmem_resp_b;
  logic [31:0] cmem_rdata_a, cmem_rdata_b;
  logic        pmem_read, pmem_write, pmem_resp;
  logic [31:0] pmem_address, pmem_wdata, pmem_rdata;
  logic [3:0]  pmem_byte_enable;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cmem_read_a(cmem_read_a), .cmem_write_a(cmem_write_a),
    .cmem_address_a(cmem_address_a), .cmem_wdata_a(cmem_wdata_a),
    .cmem_byte_enable_a(cmem_byte_enable_a), .cmem_resp_a(cmem_resp_a),
    .cmem_rdata_a(cmem_rdata_a),
    .cmem_read_b(cmem_read_b), .cmem_write_b(cmem_write_b),
    .cmem_address_b(cmem_address_b), .cmem_wdata_b(cmem_wdata_b),
    .cmem_byte_enable_b(cmem_byte_enable_b), .cmem_resp_b(cmem_resp_b),
    .cmem_rdata_b(cmem_rdata_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: at most one outstanding transaction, round-robin on conflict.
  logic        m_busy, m_port, m_wr, m_last_b;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  bit          grant_log[$];
  wire         want_a = cmem_read_a | cmem_write_a;
  wire         want_b = cmem_read_b | cmem_write_b;
  wire         pick_b = want_b & (~want_a | ~m_last_b);

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_port <= 1'b0; m_wr <= 1'b0; m_last_b <= 1'b1;
      m_addr <= '0; m_wdata <= '0; m_be <= '0;
    end else if (m_busy) begin
      if (pmem_resp) m_busy <= 1'b0;
    end else if (want_a | want_b) begin
      m_busy   <= 1'b1;
      m_port   <= pick_b;
      m_last_b <= pick_b;
      m_wr     <= pick_b ? cmem_write_b : cmem_write_a;
      m_addr   <= pick_b ? cmem_address_b : cmem_address_a;
      m_wdata  <= pick_b ? cmem_wdata_b : cmem_wdata_a;
      m_be     <= pick_b ? cmem_byte_enable_b : cmem_byte_enable_a;
      grant_log.push_back(pick_b);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("pmem_read", pmem_read, m_busy & ~m_wr);
      check("pmem_write", pmem_write, m_busy & m_wr);
      check("pmem_address", pmem_address, m_addr);
      check("pmem_wdata", pmem_wdata, m_wdata);
      check("pmem_byte_enable", pmem_byte_enable, m_be);
      check("cmem_resp_a", cmem_resp_a, m_busy & ~m_port & pmem_resp);
      check("cmem_resp_b", cmem_resp_b, m_busy & m_port & pmem_resp);
      check("cmem_rdata_a", cmem_rdata_a, pmem_rdata);
      check("cmem_rdata_b", cmem_rdata_b, pmem_rdata);
    end
  end

  // Activity counters for the literal checks, read as deltas.
  logic [31:0] watch_addr, watch_data;
  logic [3:0]  watch_be;
  int          rd_cycles = 0, wr_cycles = 0, resp_a_cnt = 0, resp_b_cnt = 0;
  logic [31:0] cap_rdata_a = '0;

  always @(negedge clk) begin
    if (pmem_read && pmem_address == watch_addr) rd_cycles <= rd_cycles + 1;
    if (pmem_write && pmem_address == watch_addr && pmem_wdata == watch_data &&
        pmem_byte_enable == watch_be) wr_cycles <= wr_cycles + 1;
    if (cmem_resp_a) begin
      resp_a_cnt  <= resp_a_cnt + 1;
      cap_rdata_a <= cmem_rdata_a;
    end
    if (cmem_resp_b) resp_b_cnt <= resp_b_cnt + 1;
  end

  // Downstream memory: answers resp_lat cycles into each request; rdata is noise otherwise.
  int          resp_lat = 1;
  logic [31:0] resp_data = '0;
  initial begin
    int cnt;
    cnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end else if (pmem_read | pmem_write) begin
        cnt++;
        if (cnt >= resp_lat) pmem_resp = 1'b1;
      end else begin
        cnt = 0;
      end
      pmem_rdata = pmem_resp ? resp_data : $urandom;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Raise a request, hold until its resp, drop it the cycle after.
  task automatic req(input bit port, input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] be);
    bit got;
    got = 1'b0;
    if (!port) begin
      cmem_read_a = rd; cmem_write_a = wr; cmem_address_a = addr;
      cmem_wdata_a = data; cmem_byte_enable_a = be;
    end else begin
      cmem_read_b = rd; cmem_write_b = wr; cmem_address_b = addr;
      cmem_wdata_b = data; cmem_byte_enable_b = be;
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (port ? cmem_resp_b : cmem_resp_a) begin
        got = 1'b1;
        break;
      end
    end
    tick();
    if (!port) begin
      cmem_read_a = 1'b0; cmem_write_a = 1'b0;
    end else begin
      cmem_read_b = 1'b0; cmem_write_b = 1'b0;
    end
    check("req_completed", got, 1'b1);
  endtask

  int rd0, wr0, ra0, rb0, l0;

  initial begin
    rst = 1'b1;
    {cmem_read_a, cmem_write_a, cmem_read_b, cmem_write_b} = '0;
    cmem_address_a = '0; cmem_wdata_a = '0; cmem_byte_enable_a = '0;
    cmem_address_b = '0; cmem_wdata_b = '0; cmem_byte_enable_b = '0;
    watch_addr = '0; watch_data = '0; watch_be = '0;
    tick();
    cmp_en = 1'b1;
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_pmem_address", pmem_address, 32'h0);
    check("rst_resp_a", cmem_resp_a, 1'b0);
    check("rst_resp_b", cmem_resp_b, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Single read on A, memory answers on the third serve cycle.
    resp_lat = 3; resp_data = 32'hDEAD_BEEF; watch_addr = 32'h60;
    rd0 = rd_cycles; ra0 = resp_a_cnt; rb0 = resp_b_cnt;
    req(1'b0, 1'b1, 1'b0, 32'h60, 32'h0, 4'hF);
    tick();
    check("t1_read_cycles", rd_cycles - rd0, 3);
    check("t1_resp_a_pulses", resp_a_cnt - ra0, 1);
    check("t1_resp_b_pulses", resp_b_cnt - rb0, 0);
    check("t1_rdata_a", cap_rdata_a, 32'hDEAD_BEEF);

    // Write on B with partial byte enables.
    resp_lat = 2; watch_addr = 32'h100; watch_data = 32'h1234_5678; watch_be = 4'b0011;
    wr0 = wr_cycles; ra0 = resp_a_cnt; rb0 = resp_b_cnt;
    req(1'b1, 1'b0, 1'b1, 32'h100, 32'h1234_5678, 4'b0011);
    tick();
    check("t2_write_cycles", wr_cycles - wr0, 2);
    check("t2_resp_b_pulses", resp_b_cnt - rb0, 1);
    check("t2_resp_a_pulses", resp_a_cnt - ra0, 0);

    // Conflict straight after reset: A first; A re-requesting then loses to waiting B.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    resp_lat = 1; l0 = grant_log.size();
    fork
      begin
        req(1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
        req(1'b0, 1'b1, 1'b0, 32'h404, 32'h0, 4'hF);
      end
      req(1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
    join
    tick();
    check("t3_grants", grant_log.size() - l0, 3);
    check("t3_first_a", grant_log[l0], 1'b0);
    check("t3_then_b", grant_log[l0+1], 1'b1);
    check("t3_then_a", grant_log[l0+2], 1'b0);

    // A requests back to back; a single B request must take the next slot.
    resp_lat = 2; l0 = grant_log.size();
    fork
      begin
        req(1'b0, 1'b1, 1'b0, 32'h600, 32'h0, 4'hF);
        req(1'b0, 1'b1, 1'b0, 32'h604, 32'h0, 4'hF);
        req(1'b0, 1'b1, 1'b0, 32'h608, 32'h0, 4'hF);
      end
      begin
        tick(); tick();
        req(1'b1, 1'b0, 1'b1, 32'h700, 32'h55AA_55AA, 4'hC);
      end
    join
    tick();
    check("t4_grants", grant_log.size() - l0, 4);
    check("t4_a_first", grant_log[l0], 1'b0);
    check("t4_b_next", grant_log[l0+1], 1'b1);

    // Reset while B is waiting on memory.
    resp_lat = 1000; rb0 = resp_b_cnt;
    cmem_read_b = 1'b1; cmem_address_b = 32'h200;
    tick();
    check("t5_serving_b", pmem_read, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    check("t5_pmem_read_off", pmem_read, 1'b0);
    check("t5_pmem_write_off", pmem_write, 1'b0);
    rst = 1'b0; cmem_read_b = 1'b0; resp_lat = 1;
    tick(); tick();
    check("t5_no_resp_b", resp_b_cnt - rb0, 0);

    // Read and write together on A: write wins.
    watch_addr = 32'h300; watch_data = 32'hCAFE_F00D; watch_be = 4'hF;
    rd0 = rd_cycles; wr0 = wr_cycles;
    req(1'b0, 1'b1, 1'b1, 32'h300, 32'hCAFE_F00D, 4'hF);
    tick();
    check("t6_write_cycles", wr_cycles - wr0, 1);
    check("t6_read_cycles", rd_cycles - rd0, 0);

    tick();
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
